// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and width defaults for the data memory port arbiter
// Contents: ADDR_W_DFLT / DATA_W_DFLT width defaults, lock FSM state enum,
//           port-2 read response owner tag enum.
package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 11;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_D    = 2'd1,
    TAG_DBG  = 2'd2
  } rsp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
// Groups: fetch (if_*), load/store (d_*), debug (dbg_*, lock), memory ports (mem_*).
// slave modport: arbiter side. master modport: requesters + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DFLT,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DFLT
);

  logic              if_req;
  logic [ADDR_W-1:0] if_adrs;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_adrs;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_adrs;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;
  logic              dbg_locked;

  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_adrs;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_r_en1;
  logic [ADDR_W-1:0] mem_r_adrs1;
  logic              mem_r_en2;
  logic [ADDR_W-1:0] mem_r_adrs2;
  logic [DATA_W-1:0] mem_data_out1;
  logic [DATA_W-1:0] mem_data_out2;

  modport slave (
    input  if_req, if_adrs,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_adrs, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  dbg_req, dbg_we, dbg_adrs, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    output mem_w_en, mem_w_adrs, mem_data_in,
    output mem_r_en1, mem_r_adrs1, mem_r_en2, mem_r_adrs2,
    input  mem_data_out1, mem_data_out2
  );

  modport master (
    output if_req, if_adrs,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_adrs, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output dbg_req, dbg_we, dbg_adrs, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    input  mem_w_en, mem_w_adrs, mem_data_in,
    input  mem_r_en1, mem_r_adrs1, mem_r_en2, mem_r_adrs2,
    output mem_data_out1, mem_data_out2
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-requester round-robin arbiter with per-requester enables
// Ports: clk, resetn (sync, active-low), en0/en1 request qualifiers,
//        req0/req1 requests, gnt0/gnt1 combinational one-hot grants.
module rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic en0,
  input  logic en1,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr = 0 favours requester 0 on the next contended cycle
  logic ptr;
  logic r0;
  logic r1;

  assign r0   = req0 & en0;
  assign r1   = req1 & en1;
  assign gnt0 = r0 & (~r1 | ~ptr);
  assign gnt1 = r1 & (~r0 | ptr);

  // Only contended cycles move the pointer; it then points at the loser.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= 1'b0;
    end else if (r0 && r1) begin
      ptr <= gnt0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-requester arbiter for the shared dual-read/single-write data memory
// Ports: clk, resetn (sync, active-low), bus (mem_port_arbiter_if.slave):
//   fetch owns read port 1; load/store and debug share read port 2 and the
//   write port round-robin; debug lock drains then grants debug exclusively.
module mem_port_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DFLT,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DFLT
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus
);

  import mem_arb_pkg::*;

  arb_state_t        state;
  logic              locked_q;
  rsp_tag_t          tag_q;
  logic              if_rvalid_q;
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;

  logic              run;
  logic              lock_st;
  logic              if_gnt;
  logic              gnt_d;
  logic              gnt_dbg;
  logic              p2_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_adrs;
  logic [DATA_W-1:0] win_wdata;
  logic              w_en;

  // Gating with resetn keeps every grant low during reset whatever the state regs hold.
  assign run     = resetn && (state == RUN);
  assign lock_st = resetn && (state == LOCKED);
  assign if_gnt  = run & bus.if_req;

  rr_arb2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .en0    (run),
    .en1    (run | lock_st),
    .req0   (bus.d_req),
    .req1   (bus.dbg_req),
    .gnt0   (gnt_d),
    .gnt1   (gnt_dbg)
  );

  assign p2_gnt = gnt_d | gnt_dbg;

  always_comb begin
    win_we    = bus.dbg_we;
    win_adrs  = bus.dbg_adrs;
    win_wdata = bus.dbg_wdata;
    if (gnt_d) begin
      win_we    = bus.d_we;
      win_adrs  = bus.d_adrs;
      win_wdata = bus.d_wdata;
    end
  end

  assign w_en = p2_gnt & win_we;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= RUN;
      locked_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.dbg_lock) state <= DRAIN;
        end
        DRAIN: begin
          state    <= LOCKED;
          locked_q <= 1'b1;
        end
        LOCKED: begin
          if (!bus.dbg_lock) begin
            state    <= RUN;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Response tracking: memory data is registered, so the owner of a read
  // granted this cycle is remembered for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q       <= TAG_NONE;
      if_rvalid_q <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      if (gnt_d && !bus.d_we) begin
        tag_q <= TAG_D;
      end else if (gnt_dbg && !bus.dbg_we) begin
        tag_q <= TAG_DBG;
      end else begin
        tag_q <= TAG_NONE;
      end
      if_rvalid_q <= if_gnt;
      // The memory returns the old word on a same-cycle read/write collision.
      byp_q       <= if_gnt && w_en && (bus.if_adrs == win_adrs);
      byp_data_q  <= win_wdata;
    end
  end

  assign bus.if_gnt      = if_gnt;
  assign bus.d_gnt       = gnt_d;
  assign bus.dbg_gnt     = gnt_dbg;
  assign bus.dbg_locked  = resetn & locked_q;

  assign bus.mem_r_en1   = if_gnt;
  assign bus.mem_r_adrs1 = bus.if_adrs;
  assign bus.mem_r_en2   = p2_gnt & ~win_we;
  assign bus.mem_r_adrs2 = win_adrs;
  assign bus.mem_w_en    = w_en;
  assign bus.mem_w_adrs  = win_adrs;
  assign bus.mem_data_in = win_wdata;

  assign bus.if_rvalid   = resetn & if_rvalid_q;
  assign bus.if_rdata    = byp_q ? byp_data_q : bus.mem_data_out1;
  assign bus.d_rvalid    = resetn && (tag_q == TAG_D);
  assign bus.d_rdata     = bus.mem_data_out2;
  assign bus.dbg_rvalid  = resetn && (tag_q == TAG_DBG);
  assign bus.dbg_rdata   = bus.mem_data_out2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  import mem_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;

  typedef struct packed {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_if[$];
  exp_t q_d[$];
  exp_t q_dbg[$];

  logic [DW-1:0] mem [0:2047];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Registered-read memory model
  always @(posedge clk) begin
    if (bus.mem_r_en1) bus.mem_data_out1 <= mem[bus.mem_r_adrs1];
    if (bus.mem_r_en2) bus.mem_data_out2 <= mem[bus.mem_r_adrs2];
    if (bus.mem_w_en)  mem[bus.mem_w_adrs] <= bus.mem_data_in;
  end

  function automatic logic [31:0] pattern(input logic [10:0] a);
    return 32'hA5A5_0000 | {21'd0, a};
  endfunction

  // Response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (q_if.size() > 0 && q_if[0].cyc < cyc) begin
      e = q_if.pop_front(); checks++; errors++;
      $display("FAIL if_rvalid_missing expected_cycle %0d now %0d", e.cyc, cyc);
    end
    if (q_d.size() > 0 && q_d[0].cyc < cyc) begin
      e = q_d.pop_front(); checks++; errors++;
      $display("FAIL d_rvalid_missing expected_cycle %0d now %0d", e.cyc, cyc);
    end
    if (q_dbg.size() > 0 && q_dbg[0].cyc < cyc) begin
      e = q_dbg.pop_front(); checks++; errors++;
      $display("FAIL dbg_rvalid_missing expected_cycle %0d now %0d", e.cyc, cyc);
    end
    if (bus.if_rvalid === 1'b1) begin
      checks++;
      if (q_if.size() == 0) begin
        errors++; $display("FAIL if_rvalid_unexpected cycle %0d data %h", cyc, bus.if_rdata);
      end else begin
        e = q_if.pop_front();
        if (e.cyc !== cyc || bus.if_rdata !== e.data) begin
          errors++;
          $display("FAIL if_rdata got %h at cycle %0d expected %h at cycle %0d", bus.if_rdata, cyc, e.data, e.cyc);
        end
      end
    end
    if (bus.d_rvalid === 1'b1) begin
      checks++;
      if (q_d.size() == 0) begin
        errors++; $display("FAIL d_rvalid_unexpected cycle %0d data %h", cyc, bus.d_rdata);
      end else begin
        e = q_d.pop_front();
        if (e.cyc !== cyc || bus.d_rdata !== e.data) begin
          errors++;
          $display("FAIL d_rdata got %h at cycle %0d expected %h at cycle %0d", bus.d_rdata, cyc, e.data, e.cyc);
        end
      end
    end
    if (bus.dbg_rvalid === 1'b1) begin
      checks++;
      if (q_dbg.size() == 0) begin
        errors++; $display("FAIL dbg_rvalid_unexpected cycle %0d data %h", cyc, bus.dbg_rdata);
      end else begin
        e = q_dbg.pop_front();
        if (e.cyc !== cyc || bus.dbg_rdata !== e.data) begin
          errors++;
          $display("FAIL dbg_rdata got %h at cycle %0d expected %h at cycle %0d", bus.dbg_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0;    bus.if_adrs = '0;
    bus.d_req = 1'b0;     bus.d_we = 1'b0;    bus.d_adrs = '0;   bus.d_wdata = '0;
    bus.dbg_req = 1'b0;   bus.dbg_we = 1'b0;  bus.dbg_adrs = '0; bus.dbg_wdata = '0;
    bus.dbg_lock = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    step(); idle(); step(); step();
    @(negedge clk);
    checks++;
    if (q_if.size() != 0 || q_d.size() != 0 || q_dbg.size() != 0) begin
      errors++;
      $display("FAIL %s_pending if %0d d %0d dbg %0d required 0 0 0", name, q_if.size(), q_d.size(), q_dbg.size());
    end
    q_if.delete(); q_d.delete(); q_dbg.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.if_req = 1'b1;  bus.if_adrs = 11'h001;
    bus.d_req = 1'b1;   bus.d_we = 1'b1;   bus.d_adrs = 11'h002;  bus.d_wdata = 32'h1111_1111;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_adrs = 11'h003;
    bus.dbg_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.if_rvalid, bus.d_rvalid, bus.dbg_rvalid,
           bus.mem_w_en, bus.mem_r_en1, bus.mem_r_en2, bus.dbg_locked} !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold outputs %b required 0000000000",
                 {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.if_rvalid, bus.d_rvalid, bus.dbg_rvalid,
                  bus.mem_w_en, bus.mem_r_en1, bus.mem_r_en2, bus.dbg_locked});
      end
    end
    step();
    resetn = 1'b1;
    idle();
    bus.d_req = 1'b1;   bus.d_adrs = 11'h040;
    bus.dbg_req = 1'b1; bus.dbg_adrs = 11'h041;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL reset_first_grant d,dbg %b required 10", {bus.d_gnt, bus.dbg_gnt});
    end
    q_d.push_back('{cyc: cyc + 1, data: pattern(11'h040)});
    drain_and_check("reset");
  endtask

  task automatic test_contention();
    step(); resetn = 1'b0; idle();
    step(); resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [10:0] fa;
      logic        exp_d;
      step();
      fa = 11'h030 + 11'(i);
      exp_d = (i % 2 == 0);
      bus.d_req = 1'b1;   bus.d_we = 1'b0;   bus.d_adrs = 11'h010;
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_adrs = 11'h020;
      bus.if_req = 1'b1;  bus.if_adrs = fa;
      @(negedge clk);
      checks++;
      if ({bus.d_gnt, bus.dbg_gnt} !== (exp_d ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant_%0d d,dbg %b required %b", i, {bus.d_gnt, bus.dbg_gnt}, exp_d ? 2'b10 : 2'b01);
      end
      checks++;
      if (bus.mem_r_en2 !== 1'b1 || bus.mem_r_adrs2 !== (exp_d ? 11'h010 : 11'h020)) begin
        errors++;
        $display("FAIL contention_port2_%0d en %b adrs %h required 1 %h", i, bus.mem_r_en2, bus.mem_r_adrs2, exp_d ? 11'h010 : 11'h020);
      end
      checks++;
      if (bus.if_gnt !== 1'b1 || bus.mem_r_en1 !== 1'b1) begin
        errors++; $display("FAIL contention_fetch_%0d gnt %b en1 %b required 1 1", i, bus.if_gnt, bus.mem_r_en1);
      end
      q_if.push_back('{cyc: cyc + 1, data: pattern(fa)});
      if (exp_d) q_d.push_back('{cyc: cyc + 1, data: pattern(11'h010)});
      else       q_dbg.push_back('{cyc: cyc + 1, data: pattern(11'h020)});
    end
    drain_and_check("contention");
  endtask

  task automatic test_bypass();
    step(); idle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adrs = 11'h155; bus.d_wdata = 32'hDEAD_BEEF;
    bus.if_req = 1'b1; bus.if_adrs = 11'h155;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.mem_w_en, bus.mem_r_en2, bus.if_gnt} !== 4'b1101) begin
      errors++; $display("FAIL bypass_grant d,w_en,r_en2,if %b required 1101", {bus.d_gnt, bus.mem_w_en, bus.mem_r_en2, bus.if_gnt});
    end
    checks++;
    if (bus.mem_w_adrs !== 11'h155 || bus.mem_data_in !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_write adrs %h data %h required 155 deadbeef", bus.mem_w_adrs, bus.mem_data_in);
    end
    q_if.push_back('{cyc: cyc + 1, data: 32'hDEAD_BEEF});
    step();
    bus.d_adrs = 11'h200; bus.d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.mem_w_en, bus.if_gnt} !== 3'b111) begin
      errors++; $display("FAIL bypass_nocollide d,w_en,if %b required 111", {bus.d_gnt, bus.mem_w_en, bus.if_gnt});
    end
    q_if.push_back('{cyc: cyc + 1, data: 32'hDEAD_BEEF});
    drain_and_check("bypass");
  endtask

  task automatic test_write_read();
    step(); idle();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_adrs = 11'h7FF; bus.dbg_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({bus.dbg_gnt, bus.mem_w_en, bus.mem_r_en2} !== 3'b110 || bus.mem_w_adrs !== 11'h7FF) begin
      errors++; $display("FAIL wr_write gnt,w_en,r_en2 %b adrs %h required 110 7ff", {bus.dbg_gnt, bus.mem_w_en, bus.mem_r_en2}, bus.mem_w_adrs);
    end
    step();
    bus.dbg_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.dbg_gnt, bus.mem_w_en, bus.mem_r_en2} !== 3'b101 || bus.mem_r_adrs2 !== 11'h7FF) begin
      errors++; $display("FAIL wr_read gnt,w_en,r_en2 %b adrs %h required 101 7ff", {bus.dbg_gnt, bus.mem_w_en, bus.mem_r_en2}, bus.mem_r_adrs2);
    end
    q_dbg.push_back('{cyc: cyc + 1, data: 32'h1234_5678});
    drain_and_check("write_read");
  endtask

  task automatic test_lock();
    step(); idle();
    bus.if_req = 1'b1; bus.if_adrs = 11'h050;
    bus.d_req = 1'b1;  bus.d_adrs = 11'h010;
    bus.dbg_lock = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b1100) begin
      errors++; $display("FAIL lock_cycle_n if,d,dbg,locked %b required 1100", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    q_if.push_back('{cyc: cyc + 1, data: pattern(11'h050)});
    q_d.push_back('{cyc: cyc + 1, data: pattern(11'h010)});
    step();
    bus.if_adrs = 11'h051;
    bus.dbg_req = 1'b1; bus.dbg_adrs = 11'h020;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b0000) begin
      errors++; $display("FAIL lock_drain if,d,dbg,locked %b required 0000", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    step();
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b0011) begin
      errors++; $display("FAIL lock_locked if,d,dbg,locked %b required 0011", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    q_dbg.push_back('{cyc: cyc + 1, data: pattern(11'h020)});
    step();
    bus.dbg_lock = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b0001) begin
      errors++; $display("FAIL lock_release if,d,dbg,locked %b required 0001", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    step();
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b1100) begin
      errors++; $display("FAIL lock_resume if,d,dbg,locked %b required 1100", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    q_if.push_back('{cyc: cyc + 1, data: pattern(11'h051)});
    q_d.push_back('{cyc: cyc + 1, data: pattern(11'h010)});
    drain_and_check("lock");
  endtask

  task automatic test_reset_mid_lock();
    step(); idle();
    bus.dbg_lock = 1'b1;
    step();
    step();
    bus.dbg_req = 1'b1; bus.dbg_adrs = 11'h021;
    @(negedge clk);
    checks++;
    if ({bus.dbg_gnt, bus.dbg_locked} !== 2'b11) begin
      errors++; $display("FAIL midlock_grant gnt,locked %b required 11", {bus.dbg_gnt, bus.dbg_locked});
    end
    step();
    resetn = 1'b0; idle();
    @(negedge clk);
    checks++;
    if ({bus.dbg_rvalid, bus.dbg_gnt, bus.dbg_locked} !== 3'b000) begin
      errors++; $display("FAIL midlock_in_reset rvalid,gnt,locked %b required 000", {bus.dbg_rvalid, bus.dbg_gnt, bus.dbg_locked});
    end
    step();
    @(negedge clk);
    checks++;
    if ({bus.dbg_rvalid, bus.dbg_locked} !== 2'b00) begin
      errors++; $display("FAIL midlock_after_edge rvalid,locked %b required 00", {bus.dbg_rvalid, bus.dbg_locked});
    end
    step();
    resetn = 1'b1;
    bus.if_req = 1'b1; bus.if_adrs = 11'h060;
    bus.d_req = 1'b1;  bus.d_adrs = 11'h011;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked} !== 4'b1100) begin
      errors++; $display("FAIL midlock_run if,d,dbg,locked %b required 1100", {bus.if_gnt, bus.d_gnt, bus.dbg_gnt, bus.dbg_locked});
    end
    q_if.push_back('{cyc: cyc + 1, data: pattern(11'h060)});
    q_d.push_back('{cyc: cyc + 1, data: pattern(11'h011)});
    drain_and_check("midlock");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = pattern(11'(i));
    bus.mem_data_out1 = '0;
    bus.mem_data_out2 = '0;
    idle();
    test_reset();
    test_contention();
    test_bypass();
    test_write_read();
    test_lock();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
